// File: rtl/ls163_cascade_if.sv
// ls163_cascade_if: control, data and carry bundle for the cascaded counter
interface ls163_cascade_if #(parameter int STAGES = 2);
  logic CLR_n;
  logic LOAD_n;
  logic ENP;
  logic ENT;
  logic [4*STAGES-1:0] D;
  logic [4*STAGES-1:0] Q;
  logic RCO;
  logic [STAGES-1:0] STAGE_RCO;
  modport master (output CLR_n, LOAD_n, ENP, ENT, D, input Q, RCO, STAGE_RCO);
  modport slave (input CLR_n, LOAD_n, ENP, ENT, D, output Q, RCO, STAGE_RCO);
endinterface

// File: rtl/ls163_cascade.sv
// ls163_cascade: chain of 74LS163-style 4-bit counters linked RCO to ENT
module ls163_cascade #(
  parameter int STAGES = 2
) (
  input logic CLK,
  input logic RST,
  ls163_cascade_if.slave bus
);
  localparam int W = 4 * STAGES;
  logic [W-1:0] q;
  logic [W-1:0] q_next;
  logic [STAGES:0] ent_c;
  assign ent_c[0] = bus.ENT;
  for (genvar k = 0; k < STAGES; k++) begin : g_carry
    assign ent_c[k+1] = ent_c[k] & (&q[4*k +: 4]);
  end
  // each stage advances when ENP and its carry-in are high, all on one edge
  always_comb begin
    q_next = q;
    for (int i = 0; i < STAGES; i++)
      if (bus.ENP && ent_c[i]) q_next[4*i +: 4] = q[4*i +: 4] + 4'd1;
  end
  // reset and clear share the zero path; load beats counting
  always_ff @(posedge CLK) begin
    if (RST || !bus.CLR_n) q <= '0;
    else q <= !bus.LOAD_n ? bus.D : q_next;
  end
  assign bus.Q = q;
  assign bus.STAGE_RCO = ent_c[STAGES:1];
  assign bus.RCO = ent_c[STAGES];
endmodule

// File: tb/tb_ls163_cascade.sv
// tb_ls163_cascade: table-driven checks of the counter chain at 1, 2 and 4 stages
module tb_ls163_cascade;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ls163_cascade_if #(.STAGES(1)) b1 ();
  ls163_cascade_if #(.STAGES(2)) b2 ();
  ls163_cascade_if #(.STAGES(4)) b4 ();
  ls163_cascade #(.STAGES(1)) dut1 (.CLK(clk), .RST(rst), .bus(b1.slave));
  ls163_cascade #(.STAGES(2)) dut2 (.CLK(clk), .RST(rst), .bus(b2.slave));
  ls163_cascade #(.STAGES(4)) dut4 (.CLK(clk), .RST(rst), .bus(b4.slave));
  typedef struct {
    logic rst;
    logic clr_n;
    logic load_n;
    logic enp;
    logic ent;
    logic [7:0] d;
    logic [7:0] q;
    logic rco;
    logic [1:0] srco;
  } vec_t;
  vec_t t1[$];
  vec_t t2[$];
  function automatic vec_t mk(logic r, logic c, logic l, logic p, logic t, logic [7:0] d,
                              logic [7:0] q, logic rc, logic [1:0] s);
    vec_t v;
    v.rst = r; v.clr_n = c; v.load_n = l; v.enp = p; v.ent = t; v.d = d;
    v.q = q; v.rco = rc; v.srco = s;
    return v;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive2(vec_t v);
    @(negedge clk);
    rst = v.rst;
    b2.CLR_n = v.clr_n;
    b2.LOAD_n = v.load_n;
    b2.ENP = v.enp;
    b2.ENT = v.ent;
    b2.D = v.d;
    @(posedge clk);
    #1;
  endtask
  task automatic run_table(string tag, vec_t t[$]);
    foreach (t[i]) begin
      drive2(t[i]);
      check($sformatf("%s[%0d].q", tag, i), 32'(b2.Q), 32'(t[i].q));
      check($sformatf("%s[%0d].rco", tag, i), 32'(b2.RCO), 32'(t[i].rco));
      check($sformatf("%s[%0d].srco", tag, i), 32'(b2.STAGE_RCO), 32'(t[i].srco));
    end
  endtask
  initial begin
    b1.CLR_n = 1; b1.LOAD_n = 1; b1.ENP = 0; b1.ENT = 0; b1.D = '0;
    b2.CLR_n = 1; b2.LOAD_n = 1; b2.ENP = 0; b2.ENT = 0; b2.D = '0;
    b4.CLR_n = 1; b4.LOAD_n = 1; b4.ENP = 0; b4.ENT = 0; b4.D = '0;
    //          rst clr ld enp ent d      q      rco srco
    t1.push_back(mk(1, 1, 1, 1, 1, 8'h00, 8'h00, 0, 2'b00));
    t1.push_back(mk(0, 1, 0, 0, 0, 8'h7C, 8'h7C, 0, 2'b00));
    t1.push_back(mk(0, 1, 1, 1, 1, 8'h00, 8'h7D, 0, 2'b00));
    t1.push_back(mk(1, 1, 1, 1, 1, 8'h00, 8'h00, 0, 2'b00));
    t2.push_back(mk(0, 1, 0, 0, 0, 8'hFE, 8'hFE, 0, 2'b00));
    t2.push_back(mk(0, 1, 1, 1, 1, 8'h00, 8'hFF, 1, 2'b11));
    t2.push_back(mk(0, 1, 1, 0, 1, 8'h00, 8'hFF, 1, 2'b11));
    t2.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'hFF, 0, 2'b00));
    t2.push_back(mk(0, 1, 1, 1, 0, 8'h00, 8'hFF, 0, 2'b00));
    t2.push_back(mk(0, 1, 1, 1, 1, 8'h00, 8'h00, 0, 2'b00));
    t2.push_back(mk(0, 1, 0, 0, 0, 8'h0F, 8'h0F, 0, 2'b00));
    t2.push_back(mk(0, 1, 1, 1, 1, 8'h00, 8'h10, 0, 2'b00));
    t2.push_back(mk(1, 0, 0, 1, 1, 8'h5A, 8'h00, 0, 2'b00));
    t2.push_back(mk(0, 1, 0, 0, 0, 8'h33, 8'h33, 0, 2'b00));
    t2.push_back(mk(0, 0, 0, 1, 1, 8'h5A, 8'h00, 0, 2'b00));
    t2.push_back(mk(0, 1, 0, 1, 1, 8'hFF, 8'hFF, 1, 2'b11));
    t2.push_back(mk(0, 1, 0, 1, 1, 8'h12, 8'h12, 0, 2'b00));
    t2.push_back(mk(0, 1, 0, 1, 1, 8'hFF, 8'hFF, 1, 2'b11));
    t2.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h00, 0, 2'b00));
    run_table("reset", t1);
    @(negedge clk);
    rst = 0;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("count[%0d].q", i), 32'(b2.Q), 32'(i % 256));
      check($sformatf("count[%0d].rco", i), 32'(b2.RCO), 32'(i == 255));
      check($sformatf("count[%0d].srco0", i), 32'(b2.STAGE_RCO[0]), 32'(i % 16 == 15));
    end
    run_table("ops", t2);
    @(negedge clk);
    rst = 0;
    b2.LOAD_n = 1; b2.CLR_n = 1; b2.ENP = 0; b2.ENT = 0;
    b1.LOAD_n = 0; b1.D = 4'hE; b1.ENP = 1; b1.ENT = 1;
    b4.LOAD_n = 0; b4.D = 16'hFFFF; b4.ENP = 0; b4.ENT = 1;
    @(posedge clk);
    #1;
    check("s1.load", 32'(b1.Q), 32'h0000_000E);
    check("s4.load", 32'(b4.Q), 32'h0000_FFFF);
    check("s4.rco", 32'(b4.RCO), 32'd1);
    check("s4.srco", 32'(b4.STAGE_RCO), 32'hF);
    @(negedge clk);
    b1.LOAD_n = 1;
    b4.LOAD_n = 1; b4.ENP = 1;
    @(posedge clk);
    #1;
    check("s1.q_f", 32'(b1.Q), 32'h0000_000F);
    check("s1.rco_f", 32'(b1.RCO), 32'd1);
    check("s4.wrap", 32'(b4.Q), 32'h0000_0000);
    check("s4.rco0", 32'(b4.RCO), 32'd0);
    @(posedge clk);
    #1;
    check("s1.wrap", 32'(b1.Q), 32'h0000_0000);
    check("s1.rco0", 32'(b1.RCO), 32'd0);
    check("s4.step", 32'(b4.Q), 32'h0000_0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ls163_cascade.md
# ls163_cascade

Cascade of STAGES synchronous 4-bit binary counters (74LS163 behaviour) chained through ripple-carry output (RCO) to parallel enable T (ENT). It forms the video/timing counter chains of the System86 model. It is the stage directly upstream of the LS00 NAND decode gates, which consume its Q and RCO outputs to generate blanking, sync and strobe terms. All state changes occur on the single system clock; there is no asynchronous behaviour.

## Interface
Parameters:
- STAGES, 2, number of cascaded 4-bit counter stages; legal range 1–4; counter width W = 4*STAGES.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous active-high system reset; highest priority.
- CLR_n  input  1  chip synchronous clear, active low.
- LOAD_n  input  1  synchronous parallel load, active low.
- ENP  input  1  count enable P, common to all stages.
- ENT  input  1  count enable T into stage 0; also gates RCO.
- D  input  W  parallel load data; D[3:0] is stage 0 (LSB nibble).
- Q  output  W  counter value; Q[3:0] is stage 0.
- RCO  output  1  ripple carry out of the final stage.
- STAGE_RCO  output  STAGES  per-stage ripple carry, bit k = RCO of stage k.

## Operation
- Rising-edge actions are evaluated in this priority order:
  1. RST=1 → Q <= 0.
  2. CLR_n=0 → Q <= 0. Enables are ignored.
  3. LOAD_n=0 → Q <= D for all stages. Enables are ignored.
  4. Otherwise each stage counts independently.
- Stage k increments modulo 16 when ENP=1 and ENT_k=1.
  - ENT_0 = ENT.
  - ENT_k = STAGE_RCO[k-1] for k ≥ 1.
  - Stages whose enable is 0 hold.
- STAGE_RCO[k] = ENT_k AND (Q nibble k == 4'hF). This is combinational from current Q and ENT.
- RCO = STAGE_RCO[STAGES-1], equivalent to ENT AND (Q == all ones).
- Net effect with ENP=ENT=1 is a W-bit binary up-counter.
  - Wrap: all ones → 0.
  - RCO is high for exactly the one cycle the counter holds all ones.
- ENP=0, ENT=1: the count holds. RCO still reflects ENT and terminal count, so a chain parked at all ones keeps RCO=1.
- ENT=0: the count holds, and RCO and all STAGE_RCO are 0 regardless of Q.
- Load or clear at terminal count: the next value is D or 0 respectively. No carry into upper stages occurs on that edge.
- RST asserted mid-count overrides CLR_n, LOAD_n and the enables on that edge.

## Timing
- Zero-delay functional model; no propagation-delay parameters.
- Q is registered: Q changes one CLK edge after the controlling inputs are sampled.
- RCO and STAGE_RCO are combinational, valid in the same cycle as Q. Downstream logic samples them on the next edge.
- Reset values (cycle after an RST edge):
  - Q = 0.
  - STAGE_RCO = 0 and RCO = 0 while Q=0, for any STAGES ≤ 4.
- Power-up before the first RST edge: Q is X. The bench must apply RST before checking.
- Latency:
  - Load → Q = D after 1 edge.
  - Clear → Q = 0 after 1 edge.
  - Carry into stage k takes effect on the same edge as stage 0's wrap. There is no per-stage ripple delay.

## Test plan
- Reset:
  - RST=1 for 1 edge with CLR_n=LOAD_n=1, ENP=ENT=1, STAGES=2 → Q=8'h00, RCO=0.
  - Asserting RST while counting at 8'h7C → Q=8'h00 next edge.
- Full count and wrap (STAGES=2, ENP=ENT=1, from 0):
  - Q steps 0..255 over 255 edges.
  - RCO=1 only at Q=8'hFF; STAGE_RCO[0]=1 at every Q=8'hxF.
  - Next edge Q=8'h00.
- Enables:
  - At Q=8'hFF with ENP=0, ENT=1 → Q holds and RCO=1.
  - Then ENT=0 → Q holds, RCO=0 and STAGE_RCO=2'b00.
- Load:
  - LOAD_n=0, D=8'hFE, ENP=ENT=0 → Q=8'hFE.
  - Release with ENP=ENT=1 → Q=8'hFF (RCO=1), then 8'h00.
- Priority:
  - RST=1 with CLR_n=0 and LOAD_n=0 → Q=0.
  - CLR_n=0 with LOAD_n=0, D=8'h5A → Q=0.
  - LOAD_n=0 at Q=8'hFF with ENP=ENT=1, D=8'h12 → Q=8'h12, no wrap.
- Width:
  - STAGES=1: from 4'hE, two edges → 4'hF (RCO=1), then 4'h0.
  - STAGES=4: from 16'hFFFF, one edge → 16'h0000.
